// File: rtl/inj_port_arbiter.sv
// Packet-level arbiter merging N_SRC credit-based flit sources into one injection port.
// Define INJ_ARB_FIXED_PRIO_EN for fixed priority (source 0 highest) instead of round-robin.
module inj_port_arbiter #(
    parameter int FLIT_SIZE = 32,
    parameter int N_SRC     = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [N_SRC-1:0]                 src_tx_i,
    input  logic [N_SRC-1:0][FLIT_SIZE-1:0]  src_data_i,
    output logic [N_SRC-1:0]                 src_credit_o,
    output logic                             tx_o,
    output logic [FLIT_SIZE-1:0]             data_o,
    input  logic                             credit_i,
    output logic [N_SRC-1:0]                 grant_o,
    output logic                             busy_o
);

    localparam int IW = $clog2(N_SRC);
    localparam logic [IW:0] N_SRC_W = (IW+1)'(N_SRC);

    typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;

    state_t               state_reg;
    logic [N_SRC-1:0]     grant_reg;
    logic [IW-1:0]        gidx_reg;
    logic [FLIT_SIZE-1:0] cnt_reg;

    logic [IW-1:0]        base_idx;
    logic [IW-1:0]        pick_idx;
    logic [IW:0]          scan_idx;
    logic [N_SRC-1:0]     pick_onehot;
    logic                 pick_valid;
    logic                 active;
    logic                 xfer;
    logic                 last_flit;

`ifdef INJ_ARB_FIXED_PRIO_EN
    assign base_idx = '0;
`else
    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] next_ptr;
    assign base_idx = ptr_reg;
    assign next_ptr = (gidx_reg == IW'(N_SRC-1)) ? '0 : gidx_reg + IW'(1);
`endif

    // First requester at or after base_idx, wrapping modulo N_SRC.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            scan_idx = {1'b0, base_idx} + (IW+1)'(k);
            if (scan_idx >= N_SRC_W) begin
                scan_idx = scan_idx - N_SRC_W;
            end
            if (!pick_valid && src_tx_i[scan_idx[IW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx[IW-1:0];
            end
        end
    end

    assign pick_onehot = N_SRC'(1) << pick_idx;

    // Datapath is a pure pass-through of the granted source.
    assign active = (state_reg != IDLE);
    assign tx_o   = active & src_tx_i[gidx_reg];
    assign data_o = active ? src_data_i[gidx_reg] : '0;
    assign xfer   = tx_o & credit_i;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_credit
            assign src_credit_o[gi] = active & grant_reg[gi] & credit_i;
        end
    endgenerate

    assign last_flit = ((state_reg == SIZE) && (data_o == '0)) ||
                       ((state_reg == PAYLOAD) && (cnt_reg == FLIT_SIZE'(1)));

    assign grant_o = grant_reg;
    assign busy_o  = active;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            gidx_reg  <= '0;
            cnt_reg   <= '0;
`ifndef INJ_ARB_FIXED_PRIO_EN
            ptr_reg   <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        grant_reg <= pick_onehot;
                        gidx_reg  <= pick_idx;
                        state_reg <= HEADER;
                    end
                end
                HEADER: begin
                    if (xfer) begin
                        state_reg <= SIZE;
                    end
                end
                SIZE: begin
                    if (xfer) begin
                        cnt_reg   <= data_o;
                        state_reg <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        cnt_reg <= cnt_reg - FLIT_SIZE'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
            // End of packet overrides the per-state next state.
            if (xfer && last_flit) begin
                grant_reg <= '0;
                state_reg <= IDLE;
`ifndef INJ_ARB_FIXED_PRIO_EN
                ptr_reg   <= next_ptr;
`endif
            end
        end
    end

endmodule

// File: tb/tb_inj_port_arbiter.sv
// Scoreboard bench for inj_port_arbiter (N_SRC=2); expectations follow INJ_ARB_FIXED_PRIO_EN.
module tb_inj_port_arbiter;
    localparam int FS = 32;
    localparam int NS = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NS-1:0]        src_tx = '0;
    logic [NS-1:0][FS-1:0] src_data = '0;
    logic [NS-1:0]        src_credit;
    logic                 tx;
    logic [FS-1:0]        data;
    logic                 credit = 1'b1;
    logic [NS-1:0]        grant;
    logic                 busy;

    always #5 clk = ~clk;

    inj_port_arbiter #(.FLIT_SIZE(FS), .N_SRC(NS)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .src_tx_i     (src_tx),
        .src_data_i   (src_data),
        .src_credit_o (src_credit),
        .tx_o         (tx),
        .data_o       (data),
        .credit_i     (credit),
        .grant_o      (grant),
        .busy_o       (busy)
    );

    typedef struct packed {
        logic [FS-1:0] data;
        logic [NS-1:0] grant;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    logic [FS-1:0] q0[$];
    logic [FS-1:0] q1[$];
    logic [NS-1:0] stall = '0;
    int            tests = 0;
    int            fails = 0;

    logic          o_tx, o_busy, o_xfer;
    logic [FS-1:0] o_data;
    logic [NS-1:0] o_grant, o_credit;

    function automatic logic [FS-1:0] pay(input logic [FS-1:0] hdr, input int i);
        return {hdr[15:0], 16'(i + 160)};
    endfunction

    task automatic add_pkt(input int s, input logic [FS-1:0] hdr, input int size);
        if (s == 0) begin
            q0.push_back(hdr);
            q0.push_back(FS'(size));
            for (int i = 0; i < size; i++) q0.push_back(pay(hdr, i));
        end else begin
            q1.push_back(hdr);
            q1.push_back(FS'(size));
            for (int i = 0; i < size; i++) q1.push_back(pay(hdr, i));
        end
    endtask

    task automatic expect_pkt(input int s, input logic [FS-1:0] hdr, input int size);
        exp_t e;
        e.grant = (s == 0) ? 2'b01 : 2'b10;
        e.data = hdr;        e.last = 1'b0;         sb.push_back(e);
        e.data = FS'(size);  e.last = (size == 0);  sb.push_back(e);
        for (int i = 0; i < size; i++) begin
            e.data = pay(hdr, i);
            e.last = (i == size - 1);
            sb.push_back(e);
        end
    endtask

    // One clock: drive sources at negedge, sample mid-cycle, consume accepted flits.
    task automatic step(input logic cr);
        @(negedge clk);
        credit      = cr;
        src_tx[0]   = (q0.size() != 0) && !stall[0];
        src_tx[1]   = (q1.size() != 0) && !stall[1];
        src_data[0] = (q0.size() != 0) ? q0[0] : '0;
        src_data[1] = (q1.size() != 0) ? q1[0] : '0;
        #1;
        o_tx     = tx;
        o_data   = data;
        o_grant  = grant;
        o_credit = src_credit;
        o_busy   = busy;
        o_xfer   = tx & credit;
        if (src_tx[0] && src_credit[0]) void'(q0.pop_front());
        if (src_tx[1] && src_credit[1]) void'(q1.pop_front());
    endtask

    task automatic test_reset();
        step(1'b1);
        step(1'b1);
        tests++;
        if ({o_tx, o_busy, o_grant, o_credit} !== '0 || o_data !== '0) begin
            fails++;
            $display("FAIL reset_state: tx=%b busy=%b grant=%b credit=%b data=%h, required all 0",
                     o_tx, o_busy, o_grant, o_credit, o_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   n = 0;
        logic idle_next = 1'b0;
        for (int p = 0; p < 3; p++) begin
            add_pkt(0, 32'h100 + p, 1);
            add_pkt(1, 32'h200 + p, 1);
        end
`ifdef INJ_ARB_FIXED_PRIO_EN
        for (int p = 0; p < 3; p++) expect_pkt(0, 32'h100 + p, 1);
        for (int p = 0; p < 3; p++) expect_pkt(1, 32'h200 + p, 1);
`else
        for (int p = 0; p < 3; p++) begin
            expect_pkt(0, 32'h100 + p, 1);
            expect_pkt(1, 32'h200 + p, 1);
        end
`endif
        while (sb.size() != 0 && n < 200) begin
            step(1'b1);
            n++;
            if (idle_next) begin
                tests++;
                if (o_busy !== 1'b0 || o_tx !== 1'b0 || o_grant !== 2'b00) begin
                    fails++;
                    $display("FAIL rr_bubble: busy=%b tx=%b grant=%b, required 0 0 00", o_busy, o_tx, o_grant);
                end
                idle_next = 1'b0;
            end
            if (o_xfer) begin
                e = sb.pop_front();
                tests++;
                if (o_data !== e.data || o_grant !== e.grant) begin
                    fails++;
                    $display("FAIL rr_flit: data=%h grant=%b, required data=%h grant=%b", o_data, o_grant, e.data, e.grant);
                end else begin
                    $display("[TB] rr flit data=%h grant=%b", o_data, o_grant);
                end
                idle_next = e.last;
            end
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL rr_timeout: %0d flits left, required 0", sb.size());
        end
    endtask

    task automatic test_single_packet();
        exp_t e;
        int   n = 0, first_tx = -1, first_x = -1, last_x = -1;
        add_pkt(0, 32'h0101, 3);
        expect_pkt(0, 32'h0101, 3);
        while (sb.size() != 0 && n < 50) begin
            step(1'b1);
            n++;
            if (o_tx && first_tx < 0) first_tx = n;
            if (o_xfer) begin
                e = sb.pop_front();
                if (first_x < 0) first_x = n;
                last_x = n;
                tests++;
                if (o_data !== e.data || o_grant !== 2'b01) begin
                    fails++;
                    $display("FAIL single_flit: data=%h grant=%b, required data=%h grant=01", o_data, o_grant, e.data);
                end else begin
                    $display("[TB] single flit data=%h", o_data);
                end
            end
        end
        tests++;
        if (first_tx != 2) begin
            fails++;
            $display("FAIL single_latency: first tx at step %0d, required 2", first_tx);
        end
        tests++;
        if (last_x - first_x != 4 || sb.size() != 0) begin
            fails++;
            $display("FAIL single_consecutive: span=%0d left=%0d, required span 4 left 0", last_x - first_x, sb.size());
        end
        step(1'b1);
        tests++;
        if (o_busy !== 1'b0 || o_credit !== 2'b00 || o_grant !== 2'b00) begin
            fails++;
            $display("FAIL single_end: busy=%b credit=%b grant=%b, required 0 00 00", o_busy, o_credit, o_grant);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   n = 0, x0 = 0;
        logic cr;
        add_pkt(0, 32'h300, 4);
        expect_pkt(0, 32'h300, 4);
        expect_pkt(1, 32'h400, 1);
        while (sb.size() != 0 && n < 100) begin
            cr = (n % 2 == 0);
            step(cr);
            n++;
            if (n == 1) add_pkt(1, 32'h400, 1);
            if (o_grant == 2'b01) begin
                tests++;
                if (o_credit !== {1'b0, cr}) begin
                    fails++;
                    $display("FAIL bp_credit: src_credit=%b, required %b", o_credit, {1'b0, cr});
                end
                if (o_xfer) x0++;
            end
            if (o_xfer) begin
                e = sb.pop_front();
                tests++;
                if (o_data !== e.data || o_grant !== e.grant) begin
                    fails++;
                    $display("FAIL bp_flit: data=%h grant=%b, required data=%h grant=%b", o_data, o_grant, e.data, e.grant);
                end else begin
                    $display("[TB] bp flit data=%h grant=%b credit=%b", o_data, o_grant, cr);
                end
            end
        end
        tests++;
        if (x0 != 6 || sb.size() != 0) begin
            fails++;
            $display("FAIL bp_count: src0 transfers=%0d left=%0d, required 6 and 0", x0, sb.size());
        end
    endtask

    task automatic test_size0_stall();
        exp_t e;
        int   n = 0, xc = 0, sc = 0;
        logic stalled;
        add_pkt(1, 32'h500, 0);
        expect_pkt(1, 32'h500, 0);
        while (sb.size() != 0 && n < 30) begin
            step(1'b1);
            n++;
            if (o_xfer) begin
                e = sb.pop_front();
                xc++;
                tests++;
                if (o_data !== e.data || o_grant !== 2'b10) begin
                    fails++;
                    $display("FAIL size0_flit: data=%h grant=%b, required data=%h grant=10", o_data, o_grant, e.data);
                end else begin
                    $display("[TB] size0 flit data=%h", o_data);
                end
            end
        end
        step(1'b1);
        tests++;
        if (xc != 2 || o_busy !== 1'b0 || o_grant !== 2'b00) begin
            fails++;
            $display("FAIL size0_end: transfers=%0d busy=%b grant=%b, required 2 0 00", xc, o_busy, o_grant);
        end
        add_pkt(0, 32'h600, 4);
        expect_pkt(0, 32'h600, 4);
        n  = 0;
        xc = 0;
        while (sb.size() != 0 && n < 60) begin
            stalled  = (xc == 4 && sc < 3);
            stall[0] = stalled;
            if (stalled) sc++;
            step(1'b1);
            n++;
            if (stalled) begin
                tests++;
                if (o_tx !== 1'b0 || o_grant !== 2'b01 || o_busy !== 1'b1) begin
                    fails++;
                    $display("FAIL stall_hold: tx=%b grant=%b busy=%b, required 0 01 1", o_tx, o_grant, o_busy);
                end
            end
            if (o_xfer) begin
                e = sb.pop_front();
                xc++;
                tests++;
                if (o_data !== e.data || o_grant !== 2'b01) begin
                    fails++;
                    $display("FAIL stall_flit: data=%h grant=%b, required data=%h grant=01", o_data, o_grant, e.data);
                end else begin
                    $display("[TB] stall flit data=%h", o_data);
                end
            end
        end
        stall = '0;
        tests++;
        if (sc != 3 || sb.size() != 0) begin
            fails++;
            $display("FAIL stall_done: stalls=%0d left=%0d, required 3 and 0", sc, sb.size());
        end
    endtask

    task automatic test_reset_mid_packet();
        exp_t e;
        int   n = 0, xc = 0;
        add_pkt(0, 32'h700, 8);
        expect_pkt(0, 32'h700, 8);
        while (xc < 4 && n < 30) begin
            step(1'b1);
            n++;
            if (o_xfer) begin
                e = sb.pop_front();
                xc++;
            end
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (tx !== 1'b0 || src_credit !== 2'b00 || grant !== 2'b00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: tx=%b credit=%b grant=%b busy=%b, required 0 00 00 0", tx, src_credit, grant, busy);
        end else begin
            $display("[TB] async reset mid-packet after %0d transfers", xc);
        end
        q0.delete();
        sb.delete();
        src_tx   = '0;
        src_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
        add_pkt(0, 32'h800, 1);
        expect_pkt(0, 32'h800, 1);
        step(1'b1);
        tests++;
        if (o_grant !== 2'b00) begin
            fails++;
            $display("FAIL post_reset_idle: grant=%b, required 00", o_grant);
        end
        step(1'b1);
        tests++;
        if (o_grant !== 2'b01 || o_tx !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_grant: grant=%b tx=%b, required 01 1", o_grant, o_tx);
        end
        n = 0;
        if (o_xfer) e = sb.pop_front();
        while (sb.size() != 0 && n < 30) begin
            step(1'b1);
            n++;
            if (o_xfer) begin
                e = sb.pop_front();
                tests++;
                if (o_data !== e.data) begin
                    fails++;
                    $display("FAIL post_reset_flit: data=%h, required %h", o_data, e.data);
                end
            end
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL post_reset_timeout: %0d flits left, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_packet();
        test_backpressure();
        test_size0_stall();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
